imem_responder: RTL
===================

Name: imem_responder

Overview:
- Instruction-memory model that sits directly upstream of the Sodor 1-stage `Core` and drives its imem response bus.
- Replaces the hardcoded `io_imem_resp_*` ties in the core bench with a loadable word-addressed memory.
- Adds configurable response latency, out-of-range and misalignment handling, and request accounting.
- The bench loads a program through a side port, then the core fetches from it.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two.
- LATENCY, 1, cycles from an accepted request to its response; legal range 1..4.
- BASE_ADDR, 32'h00000000, byte address of word 0.
- NOP_WORD, 32'h00000013, data returned for out-of-range addresses (addi x0,x0,0).
- STALL_PERIOD, 8, slot period for optional stall injection; must be >= 2.

Ports:
- clock  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_imem_req_valid  in  1  fetch request valid.
- io_imem_req_bits_addr  in  32  fetch byte address.
- io_imem_resp_valid  out  1  response valid.
- io_imem_resp_bits_data  out  32  instruction word.
- ld_en  in  1  program-load write enable.
- ld_addr  in  log2(DEPTH)  word index for load.
- ld_data  in  32  word to write.
- err_misaligned  out  1  sticky: a request had addr[1:0] != 0.
- err_oob  out  1  sticky: a request fell outside memory.
- req_count  out  32  number of accepted requests.

Behaviour:
- Reset: reset low clears the whole response pipeline asynchronously. During reset and after it, io_imem_resp_valid=0, io_imem_resp_bits_data=0, err_misaligned=0, err_oob=0, req_count=0. Memory contents are not reset.
- Acceptance: a request is accepted on every rising edge where io_imem_req_valid=1. There is no backpressure; one request per cycle is always accepted.
- Decode at acceptance:
  - off = addr - BASE_ADDR (32-bit, wraps).
  - in_range = (addr >= BASE_ADDR) && (off[31:2] < DEPTH).
  - misaligned = addr[1:0] != 0.
- Response word, by priority:
  1. misaligned -> 32'h00000000 (illegal instruction, so the core traps).
  2. else if !in_range -> NOP_WORD.
  3. else mem[off[31:2]].
- Read timing: the array is read at the acceptance edge and the word enters pipeline stage 0. It travels LATENCY-1 further register stages.
- Output timing: io_imem_resp_valid and data come from the last stage, so a request accepted at edge N is visible after edge N+LATENCY-1. LATENCY=1 means the response is registered one cycle after the request is presented.
- Idle slots: cycles with io_imem_req_valid=0 propagate valid=0. Data in an invalid slot is driven to 0.
- Response order equals request order; back-to-back requests give back-to-back responses.
- Load port: when ld_en=1, mem[ld_addr] <= ld_data at the rising edge.
  - A load and an accepted request to the same word in the same cycle: the response carries the OLD word (read-before-write).
  - A load one cycle later does not affect a request already in flight.
- Error flags: err_misaligned and err_oob set on the acceptance edge of an offending request and stay set until reset. A misaligned out-of-range request sets both flags.
- req_count increments by 1 per accepted request, wraps 0xFFFFFFFF -> 0, and is independent of stalls.
- Reset asserted mid-stream: in-flight responses are discarded and never emitted. Loads presented during reset are ignored.

Optional Feature:
- Macro: IMEM_STALL_INJECT_EN.
- Defined: a slot counter runs 0..STALL_PERIOD-1, reset to 0 and advancing every cycle. When the counter equals STALL_PERIOD-1, the request presented in that cycle is NOT accepted:
  - no pipeline entry (valid=0 slot);
  - no req_count increment;
  - no error-flag update.
  - The core sees resp_valid=0 for that slot and must re-request.
- Undefined: the counter does not exist and every valid request is accepted.

Test Plan:
- Load: load mem[0]=32'h00200313 and mem[1]=32'h00300393, reset released, LATENCY=1. Requests to addr 0 and 4 on consecutive cycles -> resp data 32'h00200313 then 32'h00300393, each with resp_valid=1 one cycle after its request; req_count=2.
- Latency sweep: LATENCY=3 with a continuous stream to 0,4,8 -> first valid 3 cycles after the first request, then valid every cycle in order, with no gaps or duplicates.
- Address errors: request addr 32'h00000002 -> data 0, err_misaligned=1. Request addr DEPTH*4 (32'h00001000) -> data 32'h00000013, err_oob=1. Both flags stay 1 until reset is asserted low.
- Load/read collision: mem[5]=A, then ld_en writes B to index 5 in the same cycle as a request to addr 20 -> response A. The next request to addr 20 -> response B.
- Reset mid-flight: LATENCY=4 with 3 requests in flight, reset pulled low asynchronously (between edges) -> resp_valid drops to 0 immediately. After release, no stale response appears and req_count=0.
- Stall injection: with IMEM_STALL_INJECT_EN, STALL_PERIOD=8, and requests every cycle for 16 cycles -> exactly 2 invalid response slots 8 cycles apart; req_count=14.

Source files
------------

// File: rtl/imem_responder.sv
// imem_responder: loadable word-addressed instruction memory with LATENCY-stage response pipeline.
// Define IMEM_STALL_INJECT_EN to refuse one request every STALL_PERIOD cycles.
module imem_responder #(
    parameter int          DEPTH        = 1024,
    parameter int          LATENCY      = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h00000000,
    parameter logic [31:0] NOP_WORD     = 32'h00000013,
    parameter int          STALL_PERIOD = 8,
    localparam int         AW           = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          io_imem_req_valid,
    input  logic [31:0]   io_imem_req_bits_addr,
    output logic          io_imem_resp_valid,
    output logic [31:0]   io_imem_resp_bits_data,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    output logic          err_misaligned,
    output logic          err_oob,
    output logic [31:0]   req_count
);
    logic [31:0] mem [DEPTH];
    logic [31:0] off_w;
    logic [31:0] word;
    logic        mis;
    logic        in_rng;
    logic        accept;
    logic        pv [LATENCY];
    logic [31:0] pd [LATENCY];

    assign off_w  = (io_imem_req_bits_addr - BASE_ADDR) >> 2;
    assign mis    = io_imem_req_bits_addr[1:0] != 2'b00;
    assign in_rng = io_imem_req_bits_addr >= BASE_ADDR && off_w < 32'(DEPTH);
    assign word   = mis ? 32'h0 : !in_rng ? NOP_WORD : mem[off_w[AW-1:0]];

`ifdef IMEM_STALL_INJECT_EN
    localparam int SW = $clog2(STALL_PERIOD);
    logic [SW-1:0] slot;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) slot <= '0;
        else        slot <= slot == SW'(STALL_PERIOD - 1) ? '0 : slot + 1'b1;
    end

    assign accept = io_imem_req_valid && slot != SW'(STALL_PERIOD - 1);
`else
    assign accept = io_imem_req_valid;
`endif

    // Memory write shares the reset so loads presented during reset are dropped; contents are never cleared.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
            err_misaligned <= 1'b0;
            err_oob        <= 1'b0;
            req_count      <= '0;
        end else begin
            pv[0] <= accept;
            pd[0] <= accept ? word : '0;
            for (int i = 1; i < LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
            if (accept) begin
                err_misaligned <= err_misaligned | mis;
                err_oob        <= err_oob | !in_rng;
                req_count      <= req_count + 32'd1;
            end
            if (ld_en) mem[ld_addr] <= ld_data;
        end
    end

    assign io_imem_resp_valid     = pv[LATENCY-1];
    assign io_imem_resp_bits_data = pd[LATENCY-1];
endmodule
